// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one request at a time to instruction memory,
// buffers the response, and hands it to the IF/ID register under hazard-unit control.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        IFIDWrite,
  input  logic        imem_en,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic        imem_wait,
  output logic [31:0] IFIDInstr,
  output logic [31:0] IFIDPC,
  output logic        IFIDValid,
  output logic [1:0]  dbg_state,
  output logic        dbg_redirect_pend
);

  // Handshake: imem_req is a one-cycle strobe qualifying imem_addr; the memory
  // answers with a one-cycle imem_ready carrying imem_rdata some cycles later.
  // Only one request is ever outstanding, so no ID is needed.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fb_q, fb_d;
  logic        redirect_pend_q, redirect_pend_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    fb_d            = fb_q;
    redirect_pend_d = redirect_pend_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_pc_d       = ifid_pc_q;
    ifid_valid_d    = ifid_valid_q;

    case (state_q)
      S_IDLE: begin
        if (BranchTaken) begin
          pc_d         = BranchTarget;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end else if (imem_en) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (BranchTaken) begin
          pc_d         = BranchTarget;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
          // A response landing in the same cycle as the redirect is already stale.
          if (imem_ready) begin
            redirect_pend_d = 1'b0;
            state_d         = S_IDLE;
          end else begin
            redirect_pend_d = 1'b1;
          end
        end else if (imem_ready) begin
          if (redirect_pend_q) begin
            redirect_pend_d = 1'b0;
            state_d         = S_IDLE;
          end else begin
            fb_d    = imem_rdata;
            state_d = S_READY;
          end
        end
      end

      S_READY: begin
        if (BranchTaken) begin
          pc_d         = BranchTarget;
          fb_d         = 32'h0;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
          state_d      = S_IDLE;
        end else if (IFIDWrite) begin
          ifid_instr_d = fb_q;
          ifid_pc_d    = pc_plus4;
          ifid_valid_d = 1'b1;
          // PCWrite low means the same PC must be fetched again.
          if (PCWrite) begin
            pc_d = pc_plus4;
          end
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      pc_q            <= RESET_PC;
      fb_q            <= 32'h0;
      redirect_pend_q <= 1'b0;
      ifid_instr_q    <= NOP_INSTR;
      ifid_pc_q       <= 32'h0;
      ifid_valid_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      fb_q            <= fb_d;
      redirect_pend_q <= redirect_pend_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_q       <= ifid_pc_d;
      ifid_valid_q    <= ifid_valid_d;
    end
  end

  // The strobe is suppressed when a redirect or reset would move the PC this edge.
  assign imem_req  = (state_q == S_IDLE) && imem_en && !BranchTaken && !rst;
  assign imem_addr = pc_q;
  assign imem_wait = (state_q == S_WAIT) && !imem_ready;

  assign IFIDInstr         = ifid_instr_q;
  assign IFIDPC            = ifid_pc_q;
  assign IFIDValid         = ifid_valid_q;
  assign dbg_state         = state_q;
  assign dbg_redirect_pend = redirect_pend_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, SHALL be the instruction word placed in IF/ID on a flush.
REQ-003 Clocking SHALL be one clock; reset SHALL be synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 PCWrite  input  1  from hazard unit; permits the PC to advance.
REQ-007 IFIDWrite  input  1  from hazard unit; permits the IF/ID register to load.
REQ-008 imem_en  input  1  from hazard unit; permits a new instruction-memory request.
REQ-009 BranchTaken  input  1  resolved branch redirect, single-cycle pulse.
REQ-010 BranchTarget  input  32  redirect address, valid with BranchTaken.
REQ-011 imem_req  output  1  one-cycle request strobe to instruction memory.
REQ-012 imem_addr  output  32  request address, equal to PC.
REQ-013 imem_rdata  input  32  instruction data, valid with imem_ready.
REQ-014 imem_ready  input  1  response strobe; one or more cycles after imem_req.
REQ-015 imem_wait  output  1  fetch outstanding, to hazard unit.
REQ-016 IFIDInstr  output  32  registered instruction to decode; feeds the hazard unit's Instr input.
REQ-017 IFIDPC  output  32  registered PC+4 of IFIDInstr.
REQ-018 IFIDValid  output  1  IFIDInstr holds a real fetched instruction.

Function
REQ-019 The FSM SHALL have three states: IDLE (no request outstanding), WAIT (request outstanding), READY (instruction held in fetch buffer FB).
REQ-020 In IDLE with imem_en=1, the block SHALL assert imem_req for exactly one cycle with imem_addr=PC and move to WAIT; with imem_en=0 it SHALL stay in IDLE.
REQ-021 imem_wait SHALL equal (state==WAIT && !imem_ready), combinationally.
REQ-022 In WAIT, imem_ready=1 SHALL capture imem_rdata into FB and move to READY, unless redirect_pend=1.
REQ-023 In READY with PCWrite=1 and IFIDWrite=1, the block SHALL load IFIDInstr<=FB, IFIDPC<=PC+4, IFIDValid<=1, PC<=PC+4 (modulo 2^32), and move to IDLE.
REQ-024 In READY with IFIDWrite=0, FB, PC and the IF/ID outputs SHALL hold, and the state SHALL remain READY (stall).
REQ-025 In READY with IFIDWrite=1 and PCWrite=0, the block SHALL load IF/ID from FB and move to IDLE without changing PC (branch-fetch case); the next request SHALL re-read the same PC.
REQ-026 BranchTaken=1 in IDLE or READY SHALL set PC<=BranchTarget, IFIDInstr<=NOP_INSTR, IFIDValid<=0, discard FB, and move to IDLE.
REQ-027 BranchTaken=1 in WAIT SHALL set PC<=BranchTarget, set redirect_pend, and load NOP into IF/ID; on the next imem_ready the data SHALL be dropped, redirect_pend cleared, and the state SHALL return to IDLE.
REQ-028 Priority SHALL be rst > BranchTaken > IFIDWrite/PCWrite.
REQ-029 imem_ready received in IDLE or READY SHALL be ignored.
REQ-030 BranchTarget SHALL be used unmodified; no alignment check is required.
REQ-031 Fetch-to-IF/ID latency SHALL be at least 2 cycles from imem_req for a one-cycle memory: request, capture, then load.

Reset
REQ-032 On rst=1 at a clock edge, the block SHALL set PC=RESET_PC, state=IDLE, redirect_pend=0, IFIDInstr=NOP_INSTR, IFIDPC=0, IFIDValid=0 and FB=0.
REQ-033 After that edge, imem_req and imem_wait SHALL be 0.
REQ-034 Reset asserted while in WAIT SHALL abandon the outstanding request, and its late imem_ready SHALL be ignored per REQ-029.
REQ-035 The first request SHALL issue in the first cycle after rst deasserts, provided imem_en=1.

Verification
REQ-036 Sequential fetch test: reset, then enable, one-cycle memory returning 32'h2001_0005 at 0x0 -> imem_req at addr 0x0; IFIDInstr=32'h2001_0005, IFIDPC=0x4, IFIDValid=1; next request at 0x4.
REQ-037 Slow-memory test: imem_ready delayed 3 cycles -> imem_wait=1 for exactly 3 cycles, PC stays 0x0, and no second imem_req is issued.
REQ-038 Stall test: hold IFIDWrite=0 for 4 cycles in READY -> IFIDInstr, IFIDPC and PC are unchanged, with no imem_req; after release the stalled instruction loads exactly once.
REQ-039 Redirect-in-WAIT test: BranchTaken=1 with BranchTarget=0x100 during WAIT -> the returning data is dropped, IFIDValid=0, and the next imem_addr=0x100.
REQ-040 Reset-mid-fetch test: rst=1 in WAIT with a late imem_ready -> state=IDLE, PC=RESET_PC, and IFIDInstr=NOP_INSTR is unaffected by the stale response.
